paddle_collision_detector: RTL and testbench

//  Responder side of the game controller's collision interface. Compares the ball box against the

---
 rtl/pong_pkg.sv | 41 ++++
 rtl/paddle_collision_detector_if.sv | 38 +++
 rtl/paddle_speed_estimator.sv | 105 ++++++++++
 rtl/paddle_collision_detector.sv | 188 ++++++++++++++++++
 tb/tb_paddle_collision_detector.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
//  Shared constants and types for the pong game controller and its paddle
//  collision detector: ball geometry, screen dimensions for both coordinate
//  spaces, detector state encoding and estimator widths.
// ---------------------------------------------------------------------------
package pong_pkg;

    localparam int BALL_SIZE        = 20;

    // Native camera space and the upscaled display space
    localparam int SCREEN_W_NATIVE  = 320;
    localparam int SCREEN_H_NATIVE  = 240;
    localparam int SCREEN_W_UPSCALE = 640;
    localparam int SCREEN_H_UPSCALE = 480;

    localparam int COORD_W          = 10;  // coordinate width on every bus
    localparam int EXT_W            = 11;  // one guard bit for box-edge math
    localparam int DELTA_W          = 11;  // |dx| + |dy| never exceeds 2046
    localparam int HIST_DEPTH       = 4;   // frames averaged by the estimator
    localparam int SUM_W            = 13;  // four deltas summed without overflow
    localparam int SPEED_MAX        = 1023;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } det_state_t;

    // Unsigned absolute difference of two coordinates, widened to DELTA_W
    function automatic logic [DELTA_W-1:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W-1:0] diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return DELTA_W'(diff);
    endfunction

endpackage

// File: rtl/paddle_collision_detector_if.sv
// ---------------------------------------------------------------------------
// paddle_collision_detector_if
//  Link between the game controller (master) and the paddle collision
//  detector (slave).
//   ball_x, ball_y        master -> slave  ball top-left corner
//   is_ball_moving_left   master -> slave  ball direction
//   game_over             master -> slave  1 disarms the detector
//   collision_detected    slave -> master  hit indication
//   estimated_speed       slave -> master  paddle speed, px/frame
// ---------------------------------------------------------------------------
interface paddle_collision_detector_if;
    import pong_pkg::*;

    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic               is_ball_moving_left;
    logic               game_over;
    logic               collision_detected;
    logic [COORD_W-1:0] estimated_speed;

    modport master (
        output ball_x,
        output ball_y,
        output is_ball_moving_left,
        output game_over,
        input  collision_detected,
        input  estimated_speed
    );

    modport slave (
        input  ball_x,
        input  ball_y,
        input  is_ball_moving_left,
        input  game_over,
        output collision_detected,
        output estimated_speed
    );
endinterface

// File: rtl/paddle_speed_estimator.sv
// ---------------------------------------------------------------------------
// paddle_speed_estimator
//  Estimates paddle speed from the per-frame motion of the tracked centroid.
//  On each frame_start the Manhattan distance to the previous centroid is
//  pushed into a 4-deep history; the live estimate is the history average,
//  saturated to 10 bits. The latched centroid doubles as the paddle position
//  used by the overlap compare, so the paddle is only sampled on frame_start.
//  Ports:
//   clk_25MHZ, reset   pixel clock, synchronous active-high reset
//   frame_start        one-cycle pulse per video frame
//   paddle_valid       tracker found the paddle this frame
//   paddle_x/paddle_y  centroid from the tracker
//   prev_x/prev_y      centroid latched on the last frame_start
//   live               averaged speed, px/frame, saturated at 1023
// ---------------------------------------------------------------------------
module paddle_speed_estimator
    import pong_pkg::*;
(
    input  logic               clk_25MHZ,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               paddle_valid,
    input  logic [COORD_W-1:0] paddle_x,
    input  logic [COORD_W-1:0] paddle_y,
    output logic [COORD_W-1:0] prev_x,
    output logic [COORD_W-1:0] prev_y,
    output logic [COORD_W-1:0] live
);

    logic [COORD_W-1:0] prev_x_reg;
    logic [COORD_W-1:0] prev_y_reg;
    logic               prev_valid_reg;

    logic [DELTA_W-1:0] delta;
    logic [DELTA_W-1:0] hist_tap [HIST_DEPTH];
    logic [SUM_W-1:0]   hist_sum;
    logic [SUM_W-3:0]   hist_avg;

    // A delta only means something when both this frame and the previous
    // one located the paddle; otherwise a lost frame would look like a jump.
    always_comb begin
        delta = '0;
        if (paddle_valid && prev_valid_reg) begin
            delta = abs_diff(paddle_x, prev_x_reg) + abs_diff(paddle_y, prev_y_reg);
        end
    end

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            prev_x_reg     <= '0;
            prev_y_reg     <= '0;
            prev_valid_reg <= 1'b0;
        end else if (frame_start) begin
            prev_x_reg     <= paddle_x;
            prev_y_reg     <= paddle_y;
            prev_valid_reg <= paddle_valid;
        end
    end

    // History shift register: entry 0 is the newest delta, the last entry
    // falls off on every frame.
    genvar gi;
    generate
        for (gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            logic [DELTA_W-1:0] entry_reg;

            if (gi == 0) begin : g_head
                always_ff @(posedge clk_25MHZ) begin
                    if (reset) begin
                        entry_reg <= '0;
                    end else if (frame_start) begin
                        entry_reg <= delta;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk_25MHZ) begin
                    if (reset) begin
                        entry_reg <= '0;
                    end else if (frame_start) begin
                        entry_reg <= g_hist[gi-1].entry_reg;
                    end
                end
            end

            assign hist_tap[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        hist_sum = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_sum = hist_sum + SUM_W'(hist_tap[i]);
        end
        hist_avg = hist_sum[SUM_W-1:2];
        if (hist_avg > (SUM_W-2)'(SPEED_MAX)) begin
            live = COORD_W'(SPEED_MAX);
        end else begin
            live = hist_avg[COORD_W-1:0];
        end
    end

    assign prev_x = prev_x_reg;
    assign prev_y = prev_y_reg;

endmodule

// File: rtl/paddle_collision_detector.sv
// ---------------------------------------------------------------------------
// paddle_collision_detector
//  Responder side of the game controller's collision link. Compares the
//  ball box with the camera-tracked paddle box and raises
//  collision_detected while the ball travels right; reports an estimate of
//  paddle speed that is frozen for the duration of a hit and its cooldown.
//  Ports:
//   clk_25MHZ           pixel clock, the only clock
//   reset               synchronous, active-high
//   upscale             1: 640x480 space (paddle box doubled), 0: 320x240
//   paddle_x/paddle_y   paddle centroid, sampled only on frame_start
//   paddle_valid        tracker found the paddle this frame
//   frame_start         one-cycle pulse per video frame
//   game_bus            slave side of the game controller link
// ---------------------------------------------------------------------------
module paddle_collision_detector #(
    parameter int BALL_SIZE       = pong_pkg::BALL_SIZE,
    parameter int PADDLE_HALF_W   = 8,
    parameter int PADDLE_HALF_H   = 32,
    parameter int HOLD_MAX        = 1024,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                              clk_25MHZ,
    input  logic                              reset,
    input  logic                              upscale,
    input  logic [pong_pkg::COORD_W-1:0]      paddle_x,
    input  logic [pong_pkg::COORD_W-1:0]      paddle_y,
    input  logic                              paddle_valid,
    input  logic                              frame_start,
    paddle_collision_detector_if.slave        game_bus
);
    import pong_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_MAX);
    localparam int COOL_W = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [COOL_W-1:0] COOL_DONE = COOL_W'(COOLDOWN_FRAMES);

    // ------------------------------------------------------------------
    // Speed estimator and latched paddle centroid
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] live;
    logic [COORD_W-1:0] paddle_cx;
    logic [COORD_W-1:0] paddle_cy;

    paddle_speed_estimator u_speed (
        .clk_25MHZ    (clk_25MHZ),
        .reset        (reset),
        .frame_start  (frame_start),
        .paddle_valid (paddle_valid),
        .paddle_x     (paddle_x),
        .paddle_y     (paddle_y),
        .prev_x       (paddle_cx),
        .prev_y       (paddle_cy),
        .live         (live)
    );

    // ------------------------------------------------------------------
    // Overlap compare. Boxes are half-open; the guard bit keeps the right
    // and bottom edges from wrapping, and the left/top edges clamp at 0
    // instead of wrapping to a huge value near the screen origin.
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] half_w;
    logic [EXT_W-1:0] half_h;
    logic [EXT_W-1:0] cx_ext;
    logic [EXT_W-1:0] cy_ext;
    logic [EXT_W-1:0] pad_left;
    logic [EXT_W-1:0] pad_right;
    logic [EXT_W-1:0] pad_top;
    logic [EXT_W-1:0] pad_bottom;
    logic [EXT_W-1:0] ball_left;
    logic [EXT_W-1:0] ball_right;
    logic [EXT_W-1:0] ball_top;
    logic [EXT_W-1:0] ball_bottom;
    logic             overlap_x;
    logic             overlap_y;
    logic             overlap;

    always_comb begin
        half_w      = EXT_W'(PADDLE_HALF_W) << upscale;
        half_h      = EXT_W'(PADDLE_HALF_H) << upscale;
        cx_ext      = EXT_W'(paddle_cx);
        cy_ext      = EXT_W'(paddle_cy);
        pad_left    = (cx_ext > half_w) ? (cx_ext - half_w) : '0;
        pad_top     = (cy_ext > half_h) ? (cy_ext - half_h) : '0;
        pad_right   = cx_ext + half_w;
        pad_bottom  = cy_ext + half_h;
        ball_left   = EXT_W'(game_bus.ball_x);
        ball_top    = EXT_W'(game_bus.ball_y);
        ball_right  = ball_left + EXT_W'(BALL_SIZE);
        ball_bottom = ball_top + EXT_W'(BALL_SIZE);
        overlap_x   = (ball_left < pad_right) && (pad_left < ball_right);
        overlap_y   = (ball_top < pad_bottom) && (pad_top < ball_bottom);
        overlap     = overlap_x && overlap_y;
    end

    // ------------------------------------------------------------------
    // Detector FSM with registered outputs
    // ------------------------------------------------------------------
    det_state_t         state_reg;
    logic               cd_reg;
    logic [COORD_W-1:0] speed_reg;
    logic [HOLD_W-1:0]  hold_cnt_reg;
    logic [COOL_W-1:0]  cool_cnt_reg;
    logic               turning_reg;   // ball reversal seen; one more cycle of cd

    always_ff @(posedge clk_25MHZ) begin
        if (reset) begin
            state_reg    <= DISARMED;
            cd_reg       <= 1'b0;
            speed_reg    <= '0;
            hold_cnt_reg <= '0;
            cool_cnt_reg <= '0;
            turning_reg  <= 1'b0;
        end else if (game_bus.game_over) begin
            // Disarm from any state, dropping cd in the same cycle
            state_reg    <= DISARMED;
            cd_reg       <= 1'b0;
            speed_reg    <= live;
            hold_cnt_reg <= '0;
            cool_cnt_reg <= '0;
            turning_reg  <= 1'b0;
        end else begin
            case (state_reg)
                DISARMED: begin
                    state_reg <= ARMED;
                    cd_reg    <= 1'b0;
                    speed_reg <= live;
                end

                ARMED: begin
                    // Level-sensitive entry: a ball already inside the
                    // paddle box when arming still counts as a hit. The
                    // speed captured here is the pre-frame_start value.
                    speed_reg <= live;
                    if (overlap && !game_bus.is_ball_moving_left) begin
                        state_reg    <= HIT;
                        cd_reg       <= 1'b1;
                        hold_cnt_reg <= '0;
                        turning_reg  <= 1'b0;
                    end else begin
                        cd_reg <= 1'b0;
                    end
                end

                HIT: begin
                    // cd stays up one cycle past the reversal so the game
                    // controller sees it from both its RIGHT and LEFT
                    // states; the hold cap covers a ball that never turns.
                    if (turning_reg || (hold_cnt_reg == HOLD_LAST)) begin
                        state_reg    <= COOLDOWN;
                        cd_reg       <= 1'b0;
                        hold_cnt_reg <= '0;
                        cool_cnt_reg <= '0;
                        turning_reg  <= 1'b0;
                    end else begin
                        cd_reg       <= 1'b1;
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        if (game_bus.is_ball_moving_left) begin
                            turning_reg <= 1'b1;
                        end
                    end
                end

                COOLDOWN: begin
                    cd_reg <= 1'b0;
                    if (frame_start && (cool_cnt_reg != COOL_DONE)) begin
                        cool_cnt_reg <= cool_cnt_reg + 1'b1;
                    end
                    // Re-arm only once the ball has left the paddle, so a
                    // lingering overlap cannot produce a second hit.
                    if ((cool_cnt_reg == COOL_DONE) && !overlap) begin
                        state_reg <= ARMED;
                    end
                end

                default: begin
                    state_reg <= DISARMED;
                    cd_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign game_bus.collision_detected = cd_reg;
    assign game_bus.estimated_speed    = speed_reg;

endmodule

// File: tb/tb_paddle_collision_detector.sv
module tb_paddle_collision_detector;
    import pong_pkg::*;

    localparam int P_BALL   = 20;
    localparam int P_HALF_W = 8;
    localparam int P_HALF_H = 32;
    localparam int P_HOLD   = 1024;
    localparam int P_COOL   = 8;

    logic       clk_25MHZ    = 1'b0;
    logic       reset        = 1'b1;
    logic       upscale      = 1'b0;
    logic       paddle_valid = 1'b0;
    logic       frame_start  = 1'b0;
    logic [9:0] paddle_x     = '0;
    logic [9:0] paddle_y     = '0;

    paddle_collision_detector_if game_bus ();

    paddle_collision_detector #(
        .BALL_SIZE       (P_BALL),
        .PADDLE_HALF_W   (P_HALF_W),
        .PADDLE_HALF_H   (P_HALF_H),
        .HOLD_MAX        (P_HOLD),
        .COOLDOWN_FRAMES (P_COOL)
    ) dut (
        .clk_25MHZ    (clk_25MHZ),
        .reset        (reset),
        .upscale      (upscale),
        .paddle_x     (paddle_x),
        .paddle_y     (paddle_y),
        .paddle_valid (paddle_valid),
        .frame_start  (frame_start),
        .game_bus     (game_bus)
    );

    always #20 clk_25MHZ = ~clk_25MHZ;

    // Scoreboard of pending expectations
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the speed estimator
    int m_hist[4];
    int m_px, m_py;
    bit m_pv;
    int m_live;
    int frozen_speed;

    // Overlap boundary table: paddle x, paddle y, ball x, ball y, upscale
    int ov_tab[15][5] = '{
        '{100, 100,  72, 100, 0}, '{100, 100,  73, 100, 0},
        '{100, 100, 107, 100, 0}, '{100, 100, 108, 100, 0},
        '{100, 100,  64, 100, 1}, '{100, 100,  65, 100, 1},
        '{100, 100, 115, 100, 1}, '{100, 100, 116, 100, 1},
        '{100, 100, 100,  48, 0}, '{100, 100, 100,  49, 0},
        '{100, 100, 100, 131, 0}, '{100, 100, 100, 132, 0},
        '{  4,   4,   0,   0, 0}, '{  4,   4,   0,   0, 1},
        '{  4,   4,   0,1000, 0}
    };

    task automatic check_result(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: got %0d", tag, observed);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic observe(input logic [31:0] observed);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_result("scoreboard_empty", observed, 32'hDEAD_BEEF);
        end else begin
            it = sb_q.pop_front();
            check_result(it.tag, observed, it.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_25MHZ);
        #1;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_hist[i] = 0;
        m_px = 0; m_py = 0; m_pv = 1'b0; m_live = 0;
    endfunction

    function automatic void model_frame(input int x, input int y, input bit v);
        int d;
        int s;
        d = (v && m_pv) ? (iabs(x - m_px) + iabs(y - m_py)) : 0;
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = d;
        m_px = x; m_py = y; m_pv = v;
        s = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        m_live = (s / 4 > 1023) ? 1023 : s / 4;
    endfunction

    function automatic bit model_overlap(input int px, input int py, input int bx,
                                         input int by, input bit up);
        int hw, hh, l, t;
        hw = up ? 2 * P_HALF_W : P_HALF_W;
        hh = up ? 2 * P_HALF_H : P_HALF_H;
        l = (px - hw < 0) ? 0 : px - hw;
        t = (py - hh < 0) ? 0 : py - hh;
        return (bx < px + hw) && (l < bx + P_BALL) && (by < py + hh) && (t < by + P_BALL);
    endfunction

    // One video frame: pulse frame_start, then check the speed output one
    // cycle after the history moved (tracking) or that it stayed frozen.
    task automatic frame(input int x, input int y, input bit v, input bit tracking);
        paddle_x     = 10'(x);
        paddle_y     = 10'(y);
        paddle_valid = v;
        frame_start  = 1'b1;
        model_frame(x, y, v);
        step(1);
        frame_start  = 1'b0;
        if (tracking) expect_val("speed_track", m_live);
        else          expect_val("speed_frozen", frozen_speed);
        step(1);
        observe(game_bus.estimated_speed);
    endtask

    task automatic set_ball(input int x, input int y, input bit left);
        game_bus.ball_x              = 10'(x);
        game_bus.ball_y              = 10'(y);
        game_bus.is_ball_moving_left = left;
    endtask

    initial begin
        #(40 * 30000);
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        set_ball(0, 400, 1'b0);
        game_bus.game_over = 1'b1;
        model_reset();
        frozen_speed = 0;

        // Reset state
        step(3);
        expect_val("reset_cd", 0);       observe(game_bus.collision_detected);
        expect_val("reset_speed", 0);    observe(game_bus.estimated_speed);
        expect_val("reset_state", DISARMED); observe(dut.state_reg);
        reset = 1'b0;
        step(1);

        // Constant-velocity paddle: estimate settles at 4 px/frame
        for (int k = 0; k < 5; k++) frame(200, 100 + 4 * k, 1'b1, 1'b1);
        expect_val("speed_const4", 4);   observe(game_bus.estimated_speed);

        // Hit, then reversal keeps cd one more cycle
        frame(305, 110, 1'b1, 1'b1);
        game_bus.game_over = 1'b0;
        expect_val("armed", ARMED);
        step(1);
        observe(dut.state_reg);
        frozen_speed = m_live;
        set_ball(300, 100, 1'b0);
        expect_val("hit_cd", 1);
        step(1);
        observe(game_bus.collision_detected);
        expect_val("hit_speed_frozen", frozen_speed); observe(game_bus.estimated_speed);
        step(3);
        game_bus.is_ball_moving_left = 1'b1;
        expect_val("turn_cd_extra", 1);
        step(1);
        observe(game_bus.collision_detected);
        expect_val("turn_cd_drop", 0);
        step(1);
        observe(game_bus.collision_detected);
        expect_val("turn_cooldown", COOLDOWN); observe(dut.state_reg);

        // Cooldown with the ball away, then an overlap moving left never hits
        set_ball(0, 400, 1'b1);
        for (int k = 0; k < P_COOL; k++) frame(305, 110, 1'b1, 1'b0);
        expect_val("rearm_state", ARMED);
        expect_val("rearm_speed", m_live);
        step(1);
        observe(dut.state_reg);
        observe(game_bus.estimated_speed);
        set_ball(300, 100, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expect_val("left_no_cd", 0);
            step(1);
            observe(game_bus.collision_detected);
        end
        expect_val("left_still_armed", ARMED); observe(dut.state_reg);

        // Overlap held through the cooldown: no second hit until it clears
        game_bus.is_ball_moving_left = 1'b0;
        expect_val("hit2_cd", 1);
        step(1);
        observe(game_bus.collision_detected);
        frozen_speed = m_live;
        game_bus.is_ball_moving_left = 1'b1;
        expect_val("hit2_drop", 0);
        step(2);
        observe(game_bus.collision_detected);
        game_bus.is_ball_moving_left = 1'b0;
        for (int k = 0; k < P_COOL + 2; k++) begin
            frame(305, 110, 1'b1, 1'b0);
            expect_val("held_no_cd", 0);
            observe(game_bus.collision_detected);
        end
        expect_val("held_cooldown", COOLDOWN); observe(dut.state_reg);
        set_ball(0, 400, 1'b0);
        expect_val("clear_rearm", ARMED);
        step(1);
        observe(dut.state_reg);

        // Direction never turns: cd held for exactly HOLD_MAX cycles
        set_ball(300, 100, 1'b0);
        expect_val("hold_hit_cd", 1);
        step(1);
        observe(game_bus.collision_detected);
        hi = 0;
        while (game_bus.collision_detected === 1'b1 && hi < 2000) begin
            hi++;
            step(1);
        end
        expect_val("hold_cycles", P_HOLD); observe(hi);
        expect_val("hold_cooldown", COOLDOWN); observe(dut.state_reg);

        // Saturating speed, then game_over in the middle of a hit
        game_bus.game_over = 1'b1;
        expect_val("go_disarmed", DISARMED);
        step(1);
        observe(dut.state_reg);
        for (int k = 0; k < 5; k++) begin
            if (k % 2 == 0) frame(0, 0, 1'b1, 1'b1);
            else            frame(639, 479, 1'b1, 1'b1);
        end
        expect_val("speed_sat", 1023); observe(game_bus.estimated_speed);
        set_ball(0, 0, 1'b0);
        game_bus.game_over = 1'b0;
        step(1);
        expect_val("sat_hit_cd", 1);
        step(1);
        observe(game_bus.collision_detected);
        expect_val("sat_hit_speed", 1023); observe(game_bus.estimated_speed);
        step(2);
        game_bus.game_over = 1'b1;
        expect_val("go_cd_drop", 0);
        expect_val("go_state", DISARMED);
        step(1);
        observe(game_bus.collision_detected);
        observe(dut.state_reg);

        // Reset in the middle of a hit
        game_bus.game_over = 1'b0;
        step(1);
        expect_val("rst_hit_cd", 1);
        step(1);
        observe(game_bus.collision_detected);
        reset = 1'b1;
        game_bus.game_over = 1'b1;
        expect_val("rst_cd_drop", 0);
        expect_val("rst_speed", 0);
        step(1);
        observe(game_bus.collision_detected);
        observe(game_bus.estimated_speed);
        model_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expect_val("rst_no_pulse", 0);
            step(1);
            observe(game_bus.collision_detected);
        end

        // Overlap boundaries, upscale and clamping at the origin
        for (int r = 0; r < 15; r++) begin
            frame(ov_tab[r][0], ov_tab[r][1], 1'b1, 1'b1);
            upscale = ov_tab[r][4][0];
            set_ball(ov_tab[r][2], ov_tab[r][3], 1'b0);
            expect_val("overlap_edge", 32'(model_overlap(ov_tab[r][0], ov_tab[r][1],
                        ov_tab[r][2], ov_tab[r][3], ov_tab[r][4][0])));
            #1;
            observe(dut.overlap);
        end
        upscale = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
